// File: rtl/axi4_pkg.sv
// Shared AXI4 definitions for the burst reader: FSM states, protocol
// constants and the AxSIZE helper.
package axi4_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam int         AXI_4KB_BOUNDARY = 4096;

  function automatic int size_from_width(input int width);
    return $clog2(width / 8);
  endfunction

endpackage

// File: rtl/axi4_burst_reader_if.sv
// AXI4 read-address/read-data channels plus the AXI4-Stream output,
// bundled for the burst reader (master) and the memory/sink side (slave).
interface axi4_burst_reader_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] m_axi_araddr;
  logic [7:0]        m_axi_arlen;
  logic [2:0]        m_axi_arsize;
  logic [1:0]        m_axi_arburst;
  logic              m_axi_arvalid;
  logic              m_axi_arready;
  logic [DATA_W-1:0] m_axi_rdata;
  logic [1:0]        m_axi_rresp;
  logic              m_axi_rlast;
  logic              m_axi_rvalid;
  logic              m_axi_rready;
  logic [DATA_W-1:0] m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic              m_axis_tlast;

  modport master (
    output m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
    input  m_axi_arready,
    input  m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    output m_axi_rready,
    output m_axis_tdata, m_axis_tvalid, m_axis_tlast,
    input  m_axis_tready
  );

  modport slave (
    input  m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
    output m_axi_arready,
    output m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    input  m_axi_rready,
    input  m_axis_tdata, m_axis_tvalid, m_axis_tlast,
    output m_axis_tready
  );
endinterface

// File: rtl/axi4_burst_len_calc.sv
// Burst length = min(max_len, beats remaining in the row, beats left before
// the next 4 KB boundary). Result is always >= 1 for a non-empty row.
module axi4_burst_len_calc
  import axi4_pkg::*;
#(
  parameter int DIM_W = 16,
  parameter int SIZE  = 2
) (
  input  logic [11:0]      addr_lo,
  input  logic [DIM_W-1:0] remaining,
  input  logic [8:0]       max_len,
  output logic [8:0]       len
);
  localparam int CW = (DIM_W > 13) ? DIM_W : 13;

  logic [12:0]   to_boundary;
  logic [CW-1:0] bound_beats;
  logic [CW-1:0] rem_w;
  logic [CW-1:0] max_w;
  logic [CW-1:0] min_a;
  logic [CW-1:0] min_b;

  always_comb begin
    to_boundary = 13'(AXI_4KB_BOUNDARY) - {1'b0, addr_lo};
    bound_beats = CW'(to_boundary >> SIZE);
    rem_w       = CW'(remaining);
    max_w       = CW'(max_len);
    min_a       = (max_w < rem_w) ? max_w : rem_w;
    min_b       = (bound_beats < min_a) ? bound_beats : min_a;
    len         = 9'(min_b);
  end
endmodule

// File: rtl/axi4_burst_reader.sv
// Reads a rows x words image region over AXI4 with one burst outstanding and
// forwards the R channel unbuffered as an AXI4-Stream with tlast per row.
module axi4_burst_reader
  import axi4_pkg::*;
#(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int MAX_BURST_LEN      = 16,
  parameter int DIM_WIDTH          = 16
) (
  input  logic                          m_axi_aclk,
  input  logic                          m_axi_aresetn,
  input  logic                          start,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] base_addr,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] row_stride,
  input  logic [DIM_WIDTH-1:0]          row_words,
  input  logic [DIM_WIDTH-1:0]          num_rows,
  output logic                          busy,
  output logic                          done,
  output logic                          error,
  axi4_burst_reader_if.master           bus
);
  localparam int AW     = C_M_AXI_ADDR_WIDTH;
  localparam int AXSIZE = size_from_width(C_M_AXI_DATA_WIDTH);

  state_e               state_q, state_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [AW-1:0]        row_addr_q, row_addr_d;
  logic [AW-1:0]        stride_q, stride_d;
  logic [DIM_WIDTH-1:0] row_words_q, row_words_d;
  logic [DIM_WIDTH-1:0] rows_left_q, rows_left_d;
  logic [DIM_WIDTH-1:0] row_left_q, row_left_d;
  logic [7:0]           arlen_q, arlen_d;
  logic                 error_q, error_d;

  logic                 in_data;
  logic                 beat_hs;
  logic [AW-1:0]        burst_bytes;
  logic [8:0]           len_next;

  assign in_data     = (state_q == ST_DATA);
  assign beat_hs     = in_data & bus.m_axi_rvalid & bus.m_axis_tready;
  assign burst_bytes = AW'(9'(arlen_q) + 9'd1) << AXSIZE;

  // Length is evaluated on the address/remaining values the next burst will use.
  axi4_burst_len_calc #(
    .DIM_W (DIM_WIDTH),
    .SIZE  (AXSIZE)
  ) u_len_calc (
    .addr_lo   (addr_d[11:0]),
    .remaining (row_left_d),
    .max_len   (9'(MAX_BURST_LEN)),
    .len       (len_next)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    row_addr_d  = row_addr_q;
    stride_d    = stride_q;
    row_words_d = row_words_q;
    rows_left_d = rows_left_q;
    row_left_d  = row_left_q;
    error_d     = error_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d      = base_addr;
          row_addr_d  = base_addr;
          stride_d    = row_stride;
          row_words_d = row_words;
          rows_left_d = num_rows;
          row_left_d  = row_words;
          error_d     = 1'b0;
          state_d     = (row_words == '0 || num_rows == '0) ? ST_DONE : ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (bus.m_axi_arready) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (beat_hs) begin
          row_left_d = row_left_q - 1'b1;
          if (bus.m_axi_rresp != AXI_RESP_OKAY) error_d = 1'b1;
          if (bus.m_axi_rlast) begin
            if (row_left_q != DIM_WIDTH'(1)) begin
              addr_d  = addr_q + burst_bytes;
              state_d = ST_ADDR;
            end else if (rows_left_q > DIM_WIDTH'(1)) begin
              rows_left_d = rows_left_q - 1'b1;
              row_addr_d  = row_addr_q + stride_q;
              addr_d      = row_addr_q + stride_q;
              row_left_d  = row_words_q;
              state_d     = ST_ADDR;
            end else begin
              state_d = ST_DONE;
            end
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    arlen_d = arlen_q;
    if (state_d == ST_ADDR && state_q != ST_ADDR) arlen_d = 8'(len_next - 9'd1);
  end

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      row_addr_q  <= '0;
      stride_q    <= '0;
      row_words_q <= '0;
      rows_left_q <= '0;
      row_left_q  <= '0;
      arlen_q     <= '0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      row_addr_q  <= row_addr_d;
      stride_q    <= stride_d;
      row_words_q <= row_words_d;
      rows_left_q <= rows_left_d;
      row_left_q  <= row_left_d;
      arlen_q     <= arlen_d;
      error_q     <= error_d;
    end
  end

  assign busy  = (state_q == ST_ADDR) || (state_q == ST_DATA);
  assign done  = (state_q == ST_DONE);
  assign error = error_q;

  assign bus.m_axi_araddr  = addr_q;
  assign bus.m_axi_arlen   = arlen_q;
  assign bus.m_axi_arsize  = 3'(AXSIZE);
  assign bus.m_axi_arburst = AXI_BURST_INCR;
  assign bus.m_axi_arvalid = (state_q == ST_ADDR);
  assign bus.m_axi_rready  = in_data & bus.m_axis_tready;
  assign bus.m_axis_tdata  = bus.m_axi_rdata;
  assign bus.m_axis_tvalid = in_data & bus.m_axi_rvalid;
  assign bus.m_axis_tlast  = in_data & bus.m_axi_rvalid & (row_left_q == DIM_WIDTH'(1));
endmodule
